// File: rtl/arb_pkg.sv
// Shared arbiter definitions: mode selector, FSM state encoding and the
// index-width helper used to size grant indices.
package arb_pkg;

  // Arbitration policy selector.
  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

  // Grant FSM states.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  // Width of a binary index able to name n requesters (never below 1 bit).
  function automatic int arb_idx_w(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational masked priority pick. Round-robin mode windows a doubled
// copy of the request vector at ptr, so the lowest set bit of that window is
// the wrapped winner without any loop-carried wrap logic. Fixed mode picks
// the highest set index and ignores ptr.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N    = 8,
  parameter int IDXW = arb_idx_w(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] ptr,
  input  arb_mode_e       mode,
  output logic [N-1:0]    onehot,
  output logic [IDXW-1:0] idx,
  output logic            any
);

  // One extra bit so positions up to 2N-1 fit.
  localparam int PW = IDXW + 1;

  logic [2*N-1:0]  dbl_s;
  logic [2*N-1:0]  mask_s;
  logic [2*N-1:0]  masked_s;
  logic [PW-1:0]   rr_pos_s;
  logic [IDXW-1:0] rr_idx_s;
  logic [IDXW-1:0] fix_idx_s;
  logic [IDXW-1:0] idx_s;

  // Window the doubled request vector so positions below ptr are hidden.
  always_comb begin
    dbl_s  = {req, req};
    mask_s = '0;
    for (int j = 0; j < 2 * N; j++) begin
      if (j >= int'(ptr)) begin
        mask_s[j] = 1'b1;
      end else begin
        mask_s[j] = 1'b0;
      end
    end
    masked_s = dbl_s & mask_s;
  end

  // Lowest set bit in the window, folded back into the range 0..N-1.
  always_comb begin
    rr_pos_s = '0;
    for (int j = 2 * N - 1; j >= 0; j--) begin
      if (masked_s[j]) begin
        rr_pos_s = PW'(j);
      end else begin
        rr_pos_s = rr_pos_s;
      end
    end
    if (rr_pos_s >= PW'(N)) begin
      rr_idx_s = IDXW'(rr_pos_s - PW'(N));
    end else begin
      rr_idx_s = IDXW'(rr_pos_s);
    end
  end

  // Highest set request index for fixed priority.
  always_comb begin
    fix_idx_s = '0;
    for (int j = 0; j < N; j++) begin
      if (req[j]) begin
        fix_idx_s = IDXW'(j);
      end else begin
        fix_idx_s = fix_idx_s;
      end
    end
  end

  // Select the winner for the active mode and expand it to one-hot.
  always_comb begin
    case (mode)
      ARB_RR:    idx_s = rr_idx_s;
      ARB_FIXED: idx_s = fix_idx_s;
      default:   idx_s = rr_idx_s;
    endcase
    idx = idx_s;
    any = |req;
    if (any) begin
      onehot = {{(N - 1){1'b0}}, 1'b1} << idx_s;
    end else begin
      onehot = '0;
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// N-way arbiter with registered, held grants and an ack handshake. A grant
// stays locked until ack; on ack the round-robin pointer moves past the
// winner and a new pick (using the moved pointer) is loaded on the same edge,
// giving back-to-back grants. All outputs come straight from registers.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int        N    = 8,
  parameter arb_mode_e MODE = ARB_RR,
  parameter int        IDXW = arb_idx_w(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic            ack,
  output logic [N-1:0]    gnt,
  output logic [IDXW-1:0] gnt_idx,
  output logic            gnt_valid
);

  arb_state_e      state_r;
  arb_state_e      state_nx_s;
  logic [IDXW-1:0] ptr_r;
  logic [IDXW-1:0] ptr_nx_s;
  logic [IDXW-1:0] ptr_inc_s;
  logic [IDXW-1:0] pick_ptr_s;
  logic [N-1:0]    pick_oh_s;
  logic [IDXW-1:0] pick_idx_s;
  logic            pick_any_s;
  logic [N-1:0]    gnt_nx_s;
  logic [IDXW-1:0] idx_nx_s;
  logic            valid_nx_s;

  // Successor of the current winner, wrapping from N-1 to 0 for any N.
  always_comb begin
    if (gnt_idx == IDXW'(N - 1)) begin
      ptr_inc_s = '0;
    end else begin
      ptr_inc_s = gnt_idx + IDXW'(1);
    end
  end

  // The pick on an ack edge must already see the advanced pointer.
  always_comb begin
    if ((state_r == ST_BUSY) && ack) begin
      pick_ptr_s = ptr_inc_s;
    end else begin
      pick_ptr_s = ptr_r;
    end
  end

  rr_pick #(
    .N    (N),
    .IDXW (IDXW)
  ) u_pick (
    .req    (req),
    .ptr    (pick_ptr_s),
    .mode   (MODE),
    .onehot (pick_oh_s),
    .idx    (pick_idx_s),
    .any    (pick_any_s)
  );

  // Next-state and next-output logic of the grant FSM.
  always_comb begin
    state_nx_s = state_r;
    ptr_nx_s   = ptr_r;
    gnt_nx_s   = gnt;
    idx_nx_s   = gnt_idx;
    valid_nx_s = gnt_valid;
    case (state_r)
      ST_IDLE: begin
        if (pick_any_s) begin
          state_nx_s = ST_BUSY;
          gnt_nx_s   = pick_oh_s;
          idx_nx_s   = pick_idx_s;
          valid_nx_s = 1'b1;
        end else begin
          state_nx_s = ST_IDLE;
          gnt_nx_s   = '0;
          idx_nx_s   = '0;
          valid_nx_s = 1'b0;
        end
      end
      ST_BUSY: begin
        if (ack) begin
          ptr_nx_s = ptr_inc_s;
          if (pick_any_s) begin
            state_nx_s = ST_BUSY;
            gnt_nx_s   = pick_oh_s;
            idx_nx_s   = pick_idx_s;
            valid_nx_s = 1'b1;
          end else begin
            state_nx_s = ST_IDLE;
            gnt_nx_s   = '0;
            idx_nx_s   = '0;
            valid_nx_s = 1'b0;
          end
        end else begin
          state_nx_s = ST_BUSY;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
        gnt_nx_s   = '0;
        idx_nx_s   = '0;
        valid_nx_s = 1'b0;
      end
    endcase
  end

  // State, pointer and output registers; reset drops any held grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      ptr_r     <= '0;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      ptr_r     <= ptr_nx_s;
      gnt       <= gnt_nx_s;
      gnt_idx   <= idx_nx_s;
      gnt_valid <= valid_nx_s;
    end
  end

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter: three instances (N=8 RR, N=5 RR, N=8 fixed) share
// clk/rst/req/ack. A directed table plus hand sequences check the documented
// scenarios; a random phase compares every instance each cycle against a
// scan-based reference model.
module tb_rr_arbiter;
  import arb_pkg::*;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       ack;

  logic [7:0] gnt8;
  logic [2:0] idx8;
  logic       val8;
  logic [4:0] gnt5;
  logic [2:0] idx5;
  logic       val5;
  logic [7:0] gntf;
  logic [2:0] idxf;
  logic       valf;

  int checks;
  int errors;

  // reference model state per instance: 0 = N8 RR, 1 = N5 RR, 2 = N8 fixed
  int m_v[3];
  int m_i[3];
  int m_p[3];
  int mn[3];
  bit mfix[3];

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic       ack;
    logic       e8v;
    int         e8i;
    logic       efv;
    int         efi;
  } vec_t;

  vec_t tv[$];

  rr_arbiter #(.N(8), .MODE(ARB_RR)) u_rr8 (
    .clk(clk), .rst(rst), .req(req), .ack(ack),
    .gnt(gnt8), .gnt_idx(idx8), .gnt_valid(val8)
  );

  rr_arbiter #(.N(5), .MODE(ARB_RR)) u_rr5 (
    .clk(clk), .rst(rst), .req(req[4:0]), .ack(ack),
    .gnt(gnt5), .gnt_idx(idx5), .gnt_valid(val5)
  );

  rr_arbiter #(.N(8), .MODE(ARB_FIXED)) u_fix8 (
    .clk(clk), .rst(rst), .req(req), .ack(ack),
    .gnt(gntf), .gnt_idx(idxf), .gnt_valid(valf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // winner by scanning from p upward modulo n, or highest index in fixed mode
  function automatic int mpick(input int n, input int p, input bit fx, input logic [7:0] r);
    if (fx) begin
      for (int i = n - 1; i >= 0; i--) if (r[i]) return i;
    end else begin
      for (int k = 0; k < n; k++) if (r[(p + k) % n]) return (p + k) % n;
    end
    return -1;
  endfunction

  task automatic model_edge();
    for (int s = 0; s < 3; s++) begin
      logic [7:0] r;
      r = (mn[s] == 5) ? (req & 8'h1F) : req;
      if (rst) begin
        m_v[s] = 0; m_i[s] = 0; m_p[s] = 0;
      end else if (m_v[s] == 0) begin
        if (r != 8'h00) begin
          m_v[s] = 1; m_i[s] = mpick(mn[s], m_p[s], mfix[s], r);
        end
      end else if (ack) begin
        m_p[s] = (m_i[s] + 1) % mn[s];
        if (r != 8'h00) m_i[s] = mpick(mn[s], m_p[s], mfix[s], r);
        else begin
          m_v[s] = 0; m_i[s] = 0;
        end
      end
    end
  endtask

  function automatic int exp_gnt(input int s);
    return (m_v[s] != 0) ? (1 << m_i[s]) : 0;
  endfunction

  task automatic check_all();
    cmp("m_val8", val8, m_v[0]);
    cmp("m_idx8", idx8, m_i[0]);
    cmp("m_gnt8", gnt8, exp_gnt(0));
    cmp("m_val5", val5, m_v[1]);
    cmp("m_idx5", idx5, m_i[1]);
    cmp("m_gnt5", gnt5, exp_gnt(1));
    cmp("m_valf", valf, m_v[2]);
    cmp("m_idxf", idxf, m_i[2]);
    cmp("m_gntf", gntf, exp_gnt(2));
  endtask

  // one clock: model follows the edge, outputs are sampled 1 time unit later
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic add(input logic r, input logic [7:0] q, input logic a,
                     input logic e8v, input int e8i, input logic efv, input int efi);
    vec_t t;
    t.rst = r; t.req = q; t.ack = a;
    t.e8v = e8v; t.e8i = e8i; t.efv = efv; t.efi = efi;
    tv.push_back(t);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    mn   = '{8, 5, 8};
    mfix = '{1'b0, 1'b0, 1'b1};
    for (int s = 0; s < 3; s++) begin
      m_v[s] = 0; m_i[s] = 0; m_p[s] = 0;
    end
    rst = 1'b1;
    req = 8'h00;
    ack = 1'b0;

    // reset held with all requests, then first grant
    for (int k = 0; k < 3; k++) add(1'b1, 8'hFF, 1'b0, 1'b0, 0, 1'b0, 0);
    add(1'b0, 8'hFF, 1'b0, 1'b1, 0, 1'b1, 7);
    add(1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 0);
    // hold without ack, even when winner drops and req[7] rises
    add(1'b0, 8'h04, 1'b0, 1'b1, 2, 1'b1, 2);
    for (int k = 0; k < 5; k++) add(1'b0, 8'h80, 1'b0, 1'b1, 2, 1'b1, 2);
    add(1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 0);
    // fairness: all requesting, ack every cycle
    add(1'b1, 8'h00, 1'b0, 1'b0, 0, 1'b0, 0);
    add(1'b0, 8'hFF, 1'b0, 1'b1, 0, 1'b1, 7);
    for (int k = 1; k <= 8; k++) add(1'b0, 8'hFF, 1'b1, 1'b1, k % 8, 1'b1, 7);
    add(1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 0);
    // sparse wrap: grant 5, ack with 0x21 -> 0
    add(1'b0, 8'h20, 1'b0, 1'b1, 5, 1'b1, 5);
    add(1'b0, 8'h21, 1'b1, 1'b1, 0, 1'b1, 5);
    add(1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 0);
    // 0x81 with ack each cycle, then bit 7 dropped
    add(1'b0, 8'h81, 1'b1, 1'b1, 7, 1'b1, 7);
    add(1'b0, 8'h81, 1'b1, 1'b1, 0, 1'b1, 7);
    add(1'b0, 8'h81, 1'b1, 1'b1, 7, 1'b1, 7);
    add(1'b0, 8'h01, 1'b1, 1'b1, 0, 1'b1, 0);
    add(1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 0);
    // reset mid-grant restores ptr to 0
    add(1'b0, 8'h08, 1'b0, 1'b1, 3, 1'b1, 3);
    add(1'b0, 8'h08, 1'b0, 1'b1, 3, 1'b1, 3);
    add(1'b1, 8'h08, 1'b0, 1'b0, 0, 1'b0, 0);
    add(1'b0, 8'h09, 1'b0, 1'b1, 0, 1'b1, 3);
    add(1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 0);

    foreach (tv[n]) begin
      rst = tv[n].rst; req = tv[n].req; ack = tv[n].ack;
      tick();
      cmp($sformatf("tbl%0d_val8", n), val8, tv[n].e8v);
      cmp($sformatf("tbl%0d_idx8", n), idx8, tv[n].e8i);
      cmp($sformatf("tbl%0d_gnt8", n), gnt8, tv[n].e8v ? (32'd1 << tv[n].e8i) : 32'd0);
      cmp($sformatf("tbl%0d_valf", n), valf, tv[n].efv);
      cmp($sformatf("tbl%0d_idxf", n), idxf, tv[n].efi);
      cmp($sformatf("tbl%0d_gntf", n), gntf, tv[n].efv ? (32'd1 << tv[n].efi) : 32'd0);
    end

    // N=5: ack of index 4 with all requesting wraps to 0
    rst = 1'b1; req = 8'h00; ack = 1'b0; tick();
    rst = 1'b0; req = 8'h10; tick();
    cmp("n5_grant4", idx5, 32'd4);
    cmp("n5_gnt4", gnt5, 32'h10);
    req = 8'h1F; ack = 1'b1; tick();
    cmp("n5_wrap_idx", idx5, 32'd0);
    cmp("n5_wrap_val", val5, 32'd1);

    // ack while idle is ignored: pointer stays at 0
    rst = 1'b1; req = 8'h00; ack = 1'b0; tick();
    rst = 1'b0; ack = 1'b1; tick();
    cmp("idle_ack_val", val8, 32'd0);
    req = 8'hFF; ack = 1'b0; tick();
    cmp("idle_ack_idx", idx8, 32'd0);
    cmp("idle_ack_gnt", gnt8, 32'h01);

    // random traffic against the reference model
    for (int k = 0; k < 600; k++) begin
      req = 8'($urandom);
      if ($urandom_range(0, 3) == 0) req = 8'h00;
      ack = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
